spi_ram_master: RTL and testbench

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

---
 rtl/spi_ram_pkg.sv | 30 +++
 rtl/spi_ram_if.sv | 25 ++
 rtl/spi_frame_engine.sv | 135 +++++++++++++
 rtl/spi_ram_master.sv | 156 +++++++++++++++
 tb/tb_spi_ram_master.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared constants and state encodings for the SPI RAM master and its frame engine.
package spi_ram_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] TYPE_WR_ADDR = 2'b00;
  localparam logic [1:0] TYPE_WR_DATA = 2'b01;
  localparam logic [1:0] TYPE_RD_ADDR = 2'b10;
  localparam logic [1:0] TYPE_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_FRM,
    S_DATA_FRM,
    S_DONE
  } top_state_e;

  // F_IDLE parks the engine between frames; the other states trace one frame.
  typedef enum logic [2:0] {
    F_IDLE,
    F_SEL,
    F_CMD,
    F_SHIFT,
    F_TURN,
    F_RECV,
    F_GAP
  } frame_state_e;

endpackage

// File: rtl/spi_ram_if.sv
// Host-side request/response bus of the SPI RAM master.
interface spi_ram_if #(
  parameter int ADDR_SIZE = 8
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_rd;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [7:0]           req_wdata;
  logic                 rsp_valid;
  logic [7:0]           rsp_rdata;
  logic                 busy;

  modport master (
    output req_valid, req_rd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_rd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/spi_frame_engine.sv
// Drives one SPI frame: select, command bit, 10-bit type/payload shift, optional
// turnaround and 8-bit receive, then the SS_n-high gap. GAP_CYCLES must be >= 1.
module spi_frame_engine
  import spi_ram_pkg::*;
#(
  parameter int GAP_CYCLES  = 1,
  parameter int TURN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           frame_type,
  input  logic [DATA_BITS-1:0] payload,
  output logic                 done,
  output logic                 active,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 ss_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CNT_MAX_0 = (GAP_CYCLES > TURN_CYCLES) ? GAP_CYCLES : TURN_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_0 > FRAME_BITS) ? CNT_MAX_0 : FRAME_BITS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  frame_state_e              state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      rd_q, rd_d;
  logic [FRAME_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]      rx_q, rx_d;

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    done    = 1'b0;
    ss_n    = 1'b1;
    mosi    = 1'b0;

    unique case (state_q)
      F_IDLE: ;
      F_SEL: begin
        ss_n    = 1'b0;
        state_d = F_CMD;
      end
      F_CMD: begin
        ss_n    = 1'b0;
        mosi    = shift_q[FRAME_BITS-1];
        cnt_d   = '0;
        state_d = F_SHIFT;
      end
      F_SHIFT: begin
        ss_n    = 1'b0;
        mosi    = shift_q[FRAME_BITS-1];
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (!rd_q)                state_d = F_GAP;
          else if (TURN_CYCLES > 0) state_d = F_TURN;
          else                      state_d = F_RECV;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      F_TURN: begin
        ss_n = 1'b0;
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = F_RECV;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      F_RECV: begin
        ss_n = 1'b0;
        rx_d = {rx_q[DATA_BITS-2:0], miso};
        if (cnt_q == RECV_LAST) begin
          cnt_d   = '0;
          state_d = F_GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      F_GAP: begin
        if (cnt_q == GAP_LAST) begin
          done    = 1'b1;
          state_d = F_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = F_IDLE;
    endcase

    // A chained frame starts straight out of the last gap cycle, with no idle bubble.
    if (start && (state_q == F_IDLE || done)) begin
      state_d = F_SEL;
      cnt_d   = '0;
      shift_d = {frame_type, payload};
      rd_d    = (frame_type == TYPE_RD_DATA);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // NOTE: shift/receive datapath is left unreset; it is always reloaded before it is observed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    rx_q    <= rx_d;
  end

  assign active = (state_q != F_IDLE);
  assign rdata  = rx_q;

endmodule

// File: rtl/spi_ram_master.sv
// Turns host read/write requests into SPI address and data frames, skipping the
// address frame when the last address sent for that direction already matches.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE     = 8,
  parameter int GAP_CYCLES    = 1,
  parameter int TURN_CYCLES   = 2,
  parameter bit ADDR_CACHE_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_ram_if.slave bus,
  output logic     SS_n,
  output logic     MOSI,
  input  logic     MISO
);

  top_state_e           state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 wc_valid_q, wc_valid_d;
  logic                 rc_valid_q, rc_valid_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;

  logic                 rd_q, rd_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] wc_addr_q, wc_addr_d;
  logic [ADDR_SIZE-1:0] rc_addr_q, rc_addr_d;

  logic                 accept;
  logic                 req_hit;
  logic [1:0]           data_type;
  logic [DATA_BITS-1:0] data_payload;

  logic                 eng_start;
  logic                 eng_done;
  logic                 eng_active;
  logic [1:0]           eng_type;
  logic [DATA_BITS-1:0] eng_payload;
  logic [DATA_BITS-1:0] eng_rdata;

  // ready_q is only ever set while heading into IDLE, so it doubles as the IDLE qualifier.
  assign accept  = ready_q && bus.req_valid;
  assign req_hit = ADDR_CACHE_EN &&
                   (bus.req_rd ? (rc_valid_q && (rc_addr_q == bus.req_addr))
                               : (wc_valid_q && (wc_addr_q == bus.req_addr)));

  assign data_type    = rd_q ? TYPE_RD_DATA : TYPE_WR_DATA;
  assign data_payload = rd_q ? '0 : wdata_q;

  always_comb begin
    state_d     = state_q;
    wc_valid_d  = wc_valid_q;
    rc_valid_d  = rc_valid_q;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wc_addr_d   = wc_addr_q;
    rc_addr_d   = rc_addr_q;
    eng_start   = 1'b0;
    eng_type    = rd_q ? TYPE_RD_ADDR : TYPE_WR_ADDR;
    eng_payload = DATA_BITS'(addr_q);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d    = bus.req_rd;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = req_hit ? S_DATA_FRM : S_ADDR_FRM;
        end
      end
      S_ADDR_FRM: begin
        if (!eng_active) begin
          eng_start = 1'b1;
        end else if (eng_done) begin
          if (rd_q) begin
            rc_valid_d = 1'b1;
            rc_addr_d  = addr_q;
          end else begin
            wc_valid_d = 1'b1;
            wc_addr_d  = addr_q;
          end
          eng_start   = 1'b1;
          eng_type    = data_type;
          eng_payload = data_payload;
          state_d     = S_DATA_FRM;
        end
      end
      S_DATA_FRM: begin
        eng_type    = data_type;
        eng_payload = data_payload;
        if (!eng_active) begin
          eng_start = 1'b1;
        end else if (eng_done) begin
          if (rd_q) rdata_d = eng_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      wc_valid_q <= 1'b0;
      rc_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      wc_valid_q <= wc_valid_d;
      rc_valid_q <= rc_valid_d;
      rdata_q    <= rdata_d;
    end
  end

  // Captured request and cached addresses are qualified by state/valid bits.
  always_ff @(posedge clk) begin
    rd_q      <= rd_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    wc_addr_q <= wc_addr_d;
    rc_addr_q <= rc_addr_d;
  end

  spi_frame_engine #(
    .GAP_CYCLES  (GAP_CYCLES),
    .TURN_CYCLES (TURN_CYCLES)
  ) u_engine (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (eng_start),
    .frame_type (eng_type),
    .payload    (eng_payload),
    .done       (eng_done),
    .active     (eng_active),
    .rdata      (eng_rdata),
    .ss_n       (SS_n),
    .mosi       (MOSI),
    .miso       (MISO)
  );

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed and random transactions against a frame-level RAM model, with an SPI slave
// that decodes frames and answers read-data frames from its own memory.
module tb_spi_ram_master;

  localparam int GAP      = 1;
  localparam int TURN     = 2;
  localparam int ADDR_LEN = 12 + GAP;             // SEL + CMD + 10 shift + gap
  localparam int RD_LEN   = 12 + TURN + 8 + GAP;  // read-data frame adds turnaround and receive

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n, mosi;
  logic miso  = 1'b0;

  spi_ram_if #(.ADDR_SIZE(8)) bus ();

  spi_ram_master #(
    .ADDR_SIZE     (8),
    .GAP_CYCLES    (GAP),
    .TURN_CYCLES   (TURN),
    .ADDR_CACHE_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .SS_n  (ss_n),
    .MOSI  (mosi),
    .MISO  (miso)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [256];
  bit          wcv, rcv;
  logic [7:0]  wca, rca;
  logic [7:0]  last_rd;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];

  function automatic logic [11:0] frm(input logic [1:0] t, input logic [7:0] p);
    return {1'b0, t[1], t, p};
  endfunction

  function automatic int model_req(input bit rd, input logic [7:0] a, input logic [7:0] d,
                                   output logic [7:0] rdata);
    int lat = 1;
    if (rd) begin
      if (!(rcv && rca == a)) begin
        exp_q.push_back(frm(2'b10, a));
        lat += ADDR_LEN;
        rcv = 1'b1;
        rca = a;
      end
      exp_q.push_back(frm(2'b11, 8'h00));
      lat += RD_LEN;
      last_rd = mem_m[a];
    end else begin
      if (!(wcv && wca == a)) begin
        exp_q.push_back(frm(2'b00, a));
        lat += ADDR_LEN;
        wcv = 1'b1;
        wca = a;
      end
      exp_q.push_back(frm(2'b01, d));
      lat += ADDR_LEN;
      mem_m[a] = d;
    end
    rdata = last_rd;
    return lat;
  endfunction

  // ---------------- SPI slave and bus monitor ----------------
  logic [7:0]  slv_mem [256];
  logic [7:0]  slv_waddr = 8'h00;
  logic [7:0]  slv_raddr = 8'h00;
  logic [7:0]  slv_byte;
  logic [11:0] cur = '0;
  int low_cnt = 0, high_run = 0;
  bit seen_frame = 1'b0;
  int mosi_viol = 0, gap_viol = 0, ready_viol = 0, rsp_count = 0;

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) rsp_count++;
    if (bus.req_ready === 1'b1 && bus.busy !== 1'b0) ready_viol++;
    if (ss_n === 1'b1) begin
      if (mosi !== 1'b0) mosi_viol++;
      if (low_cnt >= 12) begin
        obs_q.push_back(cur);
        case (cur[9:8])
          2'b00:   slv_waddr = cur[7:0];
          2'b01:   slv_mem[slv_waddr] = cur[7:0];
          2'b10:   slv_raddr = cur[7:0];
          default: ;
        endcase
        seen_frame = 1'b1;
      end
      low_cnt = 0;
      high_run++;
      miso = 1'b0;
    end else begin
      if (low_cnt == 0 && seen_frame && high_run < GAP) gap_viol++;
      high_run = 0;
      if (low_cnt < 12) cur = {cur[10:0], mosi};
      slv_byte = slv_mem[slv_raddr];
      if (low_cnt >= 14 && low_cnt < 22 && cur[9:8] == 2'b11) miso = slv_byte[21-low_cnt];
      else miso = 1'b0;
      low_cnt++;
    end
  end

  task automatic check_frames(input string tag);
    check({tag, "_nframes"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_frame"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  // Issues one request from a negedge, scrambles inputs after acceptance and measures latency.
  task automatic do_txn(input bit rd, input logic [7:0] a, input logic [7:0] d, output int lat);
    int exp_lat, w;
    logic [7:0] exp_rd;
    exp_lat = model_req(rd, a, d, exp_rd);
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_addr  = a;
    bus.req_wdata = d;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin @(negedge clk); #1; w++; end
    check("accept_wait", 32'(w < 50), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_rd    = 1'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = 8'($urandom);
    lat = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin lat++; @(negedge clk); end
    check(rd ? "rd_latency" : "wr_latency", lat, exp_lat);
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    @(negedge clk); #1;
    check_frames(rd ? "rd" : "wr");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w, c0, dummy;
    logic [7:0] rdv;
    logic [7:0] pool [4] = '{8'h05, 8'h06, 8'h07, 8'h80};
    bit b2b_rd [3]        = '{1'b0, 1'b1, 1'b0};
    logic [7:0] b2b_a [3] = '{8'h40, 8'h40, 8'h41};
    logic [7:0] b2b_d [3] = '{8'h5A, 8'h00, 8'hC3};

    for (int i = 0; i < 256; i++) begin mem_m[i] = 8'h00; slv_mem[i] = 8'h00; end
    wcv = 1'b0; rcv = 1'b0; last_rd = 8'h00;
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ss_n", ss_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", bus.req_ready, 0);
    @(negedge clk); #1;
    check("ready_after_release", bus.req_ready, 1);

    // Directed writes and reads with cache hits
    do_txn(1'b0, 8'h05, 8'h3C, lat); check("wr_full_27", lat, 27);
    do_txn(1'b0, 8'h05, 8'hA5, lat); check("wr_cached_14", lat, 14);
    do_txn(1'b1, 8'h05, 8'h00, lat); check("rd_full_37", lat, 37);
    check("rd_a5", bus.rsp_rdata, 8'hA5);
    do_txn(1'b1, 8'h05, 8'h00, lat); check("rd_cached_24", lat, 24);

    // Reset during the SHIFT of a cached write-data frame
    bus.req_valid = 1'b1; bus.req_rd = 1'b0; bus.req_addr = 8'h05; bus.req_wdata = 8'h11;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin @(negedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 check("abort_in_frame", ss_n, 0);
    c0 = rsp_count;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("abort_ss_n", ss_n, 1);
    check("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_rsp", rsp_count - c0, 0);
    check("abort_rdata_cleared", bus.rsp_rdata, 0);
    wcv = 1'b0; rcv = 1'b0; last_rd = 8'h00;
    check_frames("abort");
    do_txn(1'b0, 8'h05, 8'h77, lat); check("wr_after_abort_27", lat, 27);
    do_txn(1'b1, 8'h05, 8'h00, lat); check("rd_after_abort", bus.rsp_rdata, 8'h77);

    // Random traffic over a small address pool so both caches hit and miss
    for (int i = 0; i < 24; i++)
      do_txn(1'($urandom), pool[$urandom_range(0, 3)], 8'($urandom), lat);

    // Back-to-back requests with req_valid held high
    c0 = rsp_count;
    for (int i = 0; i < 3; i++) begin
      dummy = model_req(b2b_rd[i], b2b_a[i], b2b_d[i], rdv);
      bus.req_valid = 1'b1;
      bus.req_rd    = b2b_rd[i];
      bus.req_addr  = b2b_a[i];
      bus.req_wdata = b2b_d[i];
      w = 0;
      while (bus.req_ready !== 1'b1 && w < 100) begin @(negedge clk); #1; w++; end
      check("b2b_accept", 32'(w < 100), 1);
      check("b2b_idle_at_accept", bus.busy, 0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    w = 0;
    while (rsp_count < c0 + 3 && w < 200) begin @(negedge clk); #1; w++; end
    repeat (3) @(negedge clk);
    #1;
    check("b2b_rsp_count", rsp_count - c0, 3);
    check("b2b_rdata_hold", bus.rsp_rdata, rdv);
    check_frames("b2b");

    check("mosi_low_when_deselected", mosi_viol, 0);
    check("gap_between_frames", gap_viol, 0);
    check("ready_only_in_idle", ready_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
